// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, default width, counter sizing.
// Latency: none (package only).
// Backpressure: none (package only).
package div_pkg;

  // Operand/result width used when the instantiating code does not override it.
  localparam int DIV_WIDTH_DEFAULT = 32;

  // Controller states: waiting for a request, iterating, final correction/sign fix.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Iteration counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational non-restoring division iteration on unsigned magnitudes.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   pr,
  input  logic [WIDTH-1:0] qsr,
  input  logic [WIDTH-1:0] mb,
  output logic [WIDTH:0]   pr_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] mb_ext;

  // Shift the next dividend bit into the remainder, then add or subtract the divisor
  // depending on the sign of the previous partial remainder. The true result always
  // lies in [-mb, mb), so modulo-2^(WIDTH+1) arithmetic on WIDTH+1 bits is exact and
  // dropping the old sign bit during the shift loses nothing.
  always_comb begin
    shifted = {pr[WIDTH-1:0], qsr[WIDTH-1]};
    mb_ext  = {1'b0, mb};
    if (pr[WIDTH]) begin
      pr_nxt = shifted + mb_ext;
    end else begin
      pr_nxt = shifted - mb_ext;
    end
    q_nxt = {qsr[WIDTH-2:0], ~pr_nxt[WIDTH]};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed/unsigned divider, one quotient bit per clock (non-restoring).
// Latency: WIDTH+1 cycles start-to-done; divide-by-zero completes in 1 cycle.
// Backpressure: start is ignored while busy; results hold until the next done.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  state_t state;
  state_t state_nxt;

  // Working registers: partial remainder, quotient/dividend shift register,
  // divisor magnitude, remaining iterations and the flags captured with start.
  logic [WIDTH:0]   pr;
  logic [WIDTH-1:0] qsr;
  logic [WIDTH-1:0] mb;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             dz_f;

  logic [WIDTH:0]   step_pr;
  logic [WIDTH-1:0] step_q;

  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Operand preprocessing: magnitudes for signed mode, zero-divisor detect.
  always_comb begin
    b_zero = (b == '0);
    a_mag  = (sgn && a[WIDTH-1]) ? ('0 - a) : a;
    b_mag  = (sgn && b[WIDTH-1]) ? ('0 - b) : b;
  end

  // Final correction: restore a negative remainder, then apply result signs.
  // The corrected remainder is in [0, mb) so WIDTH-bit arithmetic suffices.
  // For a zero divisor the shift register still holds the raw dividend.
  always_comb begin
    rem_fix = pr[WIDTH] ? (pr[WIDTH-1:0] + mb) : pr[WIDTH-1:0];
    if (dz_f) begin
      q_fix = '1;
      r_fix = qsr;
    end else begin
      q_fix = neg_q ? ('0 - qsr) : qsr;
      r_fix = neg_r ? ('0 - rem_fix) : rem_fix;
    end
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .pr     (pr),
    .qsr    (qsr),
    .mb     (mb),
    .pr_nxt (step_pr),
    .q_nxt  (step_q)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; a zero divisor skips the iterations entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = b_zero ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt == CNT_ONE) begin
          state_nxt = ST_FIX;
        end
      end
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: busy covers both the iteration and the fix cycles.
  always_comb begin
    busy = (state != ST_IDLE);
  end

  // Datapath: load on accepted start, iterate in CALC, publish results in FIX.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pr    <= '0;
      qsr   <= '0;
      mb    <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz_f  <= 1'b0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pr    <= '0;
            qsr   <= b_zero ? a : a_mag;
            mb    <= b_mag;
            cnt   <= CNT_LOAD;
            neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= sgn && a[WIDTH-1];
            dz_f  <= b_zero;
          end
        end
        ST_CALC: begin
          pr  <= step_pr;
          qsr <= step_q;
          cnt <= cnt - CNT_ONE;
        end
        ST_FIX: begin
          q    <= q_fix;
          r    <= r_fix;
          dz   <= dz_f;
          done <= 1'b1;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at WIDTH=32: directed corner cases plus random ops.
// Latency: checks start-to-done cycle counts against the expected figures.
// Backpressure: exercises start held high and operands changing while busy.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         clr_n = 1'b0;
  logic         start = 1'b0;
  logic         sgn   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         done;
  logic         dz;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic done_d = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .start (start),
    .sgn   (sgn),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // done must never last two cycles; also count pulses.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_single_cycle", {63'd0, done_d}, 64'd0);
    end
    done_d = done;
  end

  // Reference: plain integer division on 64-bit values.
  function automatic void ref_div(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] eq, output logic [W-1:0] er,
                                  output logic ed);
    longint sx, sy, qq, rr;
    if (y == '0) begin
      eq = '1;
      er = x;
      ed = 1'b1;
    end else begin
      if (s) begin
        sx = $signed(x);
        sy = $signed(y);
      end else begin
        sx = longint'(x);
        sy = longint'(y);
      end
      qq = sx / sy;
      rr = sx % sy;
      eq = qq[W-1:0];
      er = rr[W-1:0];
      ed = 1'b0;
    end
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input int n, input logic [W-1:0] eq,
                              input logic [W-1:0] er, input logic ed);
    chk({tag, "_latency"}, 64'(n), ed ? 64'd1 : 64'(W + 1));
    chk({tag, "_q"}, 64'(q), 64'(eq));
    chk({tag, "_r"}, 64'(r), 64'(er));
    chk({tag, "_dz"}, {63'd0, dz}, {63'd0, ed});
    chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
  endtask

  // Called just after a rising edge; the next edge accepts the request.
  task automatic run_op(input string tag, input logic s, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic ed);
    int n;
    sgn   = s;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    sgn   = ~s;
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    wait_done(n);
    check_result(tag, n, eq, er, ed);
    @(posedge clk);
    #1;
    chk({tag, "_done_low"}, {63'd0, done}, 64'd0);
  endtask

  task automatic run_rand(input string tag, input logic s, input logic [W-1:0] x,
                          input logic [W-1:0] y);
    logic [W-1:0] eq, er;
    logic ed;
    ref_div(s, x, y, eq, er, ed);
    run_op(tag, s, x, y, eq, er, ed);
  endtask

  initial begin
    int n;
    int dc;
    logic [W-1:0] x, y, eq1, er1, eq2, er2;
    logic ed1, ed2;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_r", 64'(r), 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dz", {63'd0, dz}, 64'd0);
    clr_n = 1'b1;

    // Directed cases.
    run_op("unsigned_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_op("signed_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    run_op("dz_unsigned", 1'b0, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1'b1);
    run_op("dz_signed", 1'b1, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1'b1);
    run_op("signed_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
    run_op("signed_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
    run_op("signed_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0);
    run_op("unsigned_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
    run_op("unsigned_small_big", 1'b0, 32'd5, 32'hFFFFFFFF, 32'd0, 32'd5, 1'b0);

    // Random operations against the reference model.
    for (int i = 0; i < 16; i++) begin
      x = $urandom;
      case ($urandom_range(0, 5))
        0:       y = '0;
        1:       y = 32'($urandom_range(1, 15));
        2:       y = 32'hFFFFFFFF - 32'($urandom_range(0, 15));
        default: y = $urandom;
      endcase
      run_rand($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), x, y);
    end

    // start held high: operands wander while busy, second op accepted in done cycle.
    ref_div(1'b0, 32'd1000, 32'd33, eq1, er1, ed1);
    ref_div(1'b1, 32'hFFFFFC18, 32'd9, eq2, er2, ed2);
    sgn   = 1'b0;
    a     = 32'd1000;
    b     = 32'd33;
    start = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (n == 5) begin
        a   = $urandom;
        b   = 32'd0;
        sgn = 1'b1;
      end
      if (n == 20) begin
        a   = 32'hFFFFFC18;
        b   = 32'd9;
        sgn = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    check_result("held_first", n, eq1, er1, ed1);
    @(posedge clk);
    #1;
    chk("held_second_busy", {63'd0, busy}, 64'd1);
    chk("held_second_done_low", {63'd0, done}, 64'd0);
    start = 1'b0;
    wait_done(n);
    check_result("held_second", n, eq2, er2, ed2);
    @(posedge clk);
    #1;

    // Reset in the middle of a division, then an immediate new request.
    sgn   = 1'b0;
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("abort_busy_before", {63'd0, busy}, 64'd1);
    dc = done_cnt;
    clr_n = 1'b0;
    #1;
    chk("abort_q", 64'(q), 64'd0);
    chk("abort_r", 64'(r), 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_dz", {63'd0, dz}, 64'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("abort_hold_done", {63'd0, done}, 64'd0);
    end
    clr_n = 1'b1;
    run_op("after_reset_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    chk("abort_no_extra_done", 64'(done_cnt - dc), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
